freq_meas_ctrl: RTL and testbench
=================================

// Module: freq_meas_ctrl
// PURPOSE
//  Sequences one frequency measurement of the frequency meter: clears the external
//  edge counter, opens a gate window of exact length, waits for the input synchroniser
//  to settle, then pulses a latch that captures the count into the display register.
//  Sits between the key/mode inputs and the measured-signal counter; all timing is
//  derived from sys_clk.
// PARAMETERS
//  GATE_CYCLES   50_000_000  gate length at range 0 (1 s at 50 MHz); range r uses GATE_CYCLES/10^r
//  SETTLE_CYCLES 4           cycles between gate close and latch (>=1)
//  TW            26          gate timer width; must hold GATE_CYCLES-1
// PORTS
//  sys_clk  in  1   system clock
//  reset    in  1   synchronous, active-high reset
//  start    in  1   single-cycle request to begin a measurement
//  cont     in  1   level: re-measure continuously while high
//  ovf      in  1   external counter overflow flag (sampled while cnt_en=1)
//  cnt_clr  out 1   one-cycle clear pulse to the external counter
//  cnt_en   out 1   gate: external counter counts while high
//  latch    out 1   one-cycle capture pulse to the display register
//  done     out 1   one-cycle pulse, coincident with latch
//  busy     out 1   high in every state except IDLE
//  range    out 2   active gate range: 0 = 1 s, 1 = 100 ms, 2 = 10 ms
//  err      out 1   sticky: overflow at the shortest usable range; cleared by start
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE; every output 0; range=0; err=0; timer=0.
//  States: IDLE -> CLEAR -> GATE -> SETTLE -> LATCH -> IDLE.
//  IDLE:   start=1 -> CLEAR, range:=0, err:=0. cont=1 (no start) -> CLEAR, range held.
//  CLEAR:  one cycle; cnt_clr=1; timer:=gate length for range - 1; ovf_seen:=0 -> GATE.
//  GATE:   cnt_en=1 for exactly gate-length cycles; ovf_seen |= ovf; timer counts down,
//          exits to SETTLE when timer==0 (no wrap).
//  SETTLE: SETTLE_CYCLES cycles, cnt_en=0; ovf_seen still ORed with ovf -> LATCH.
//  LATCH:  one cycle; action depends on ovf_seen and AUTO_RANGE_EN (see CONFIGURATION).
//  Latency: start sampled at edge k -> cnt_clr during k+1, cnt_en during
//   k+2..k+1+G, latch/done at k+2+G+SETTLE_CYCLES (G = current gate length).
//  start while busy=1: ignored. start and cont both high in IDLE: start wins (range reset).
//  cont dropped mid-measurement: measurement completes, then stays in IDLE.
//  cont held: IDLE occupies exactly one cycle between measurements.
//  ovf outside GATE/SETTLE: ignored.
//  Gate lengths: integer divide, computed at elaboration; GATE_CYCLES/100 >= 1 required.
// CONFIGURATION
//  AUTO_RANGE_EN defined: in LATCH with ovf_seen=1 and range<2 -> range+1, no latch/done,
//   go to CLEAR (re-measure at the shorter gate). ovf_seen=1 at range 2 -> latch, done,
//   err:=1 -> IDLE. ovf_seen=0 -> latch, done -> IDLE.
//  AUTO_RANGE_EN undefined: range tied to 0; LATCH always pulses latch/done;
//   err:=ovf_seen; -> IDLE.
// STRUCTURE
//  Package freq_meas_pkg: state encoding (IDLE, CLEAR, GATE, SETTLE, LATCH), range codes
//   (RANGE_1S, RANGE_100MS, RANGE_10MS), gate-length constant function.
//  Sub-module gate_timer: loadable TW-bit down counter with load, enable and zero flag;
//   reused for both the GATE and SETTLE intervals.
//  Top: FSM, ovf_seen/err/range registers, registered outputs.
// TESTING (GATE_CYCLES=1000, SETTLE_CYCLES=4)
//  1. Reset, start at edge 0 -> cnt_clr at 1; cnt_en for 1000 cycles (2..1001); latch+done at 1006; busy=0 at 1007.
//  2. AUTO_RANGE_EN, ovf pulsed at cycle 500 -> no latch at 1006; range=1; cnt_clr, 100-cycle gate; latch at 1112; err=0.
//  3. AUTO_RANGE_EN, ovf held high -> range 0->1->2, latch once at end of 10-cycle gate, err=1; next start clears err, range=0.
//  4. cont=1 for 3 measurements -> 3 latch pulses spaced 1007 cycles apart; drop cont mid-gate -> 4th completes, then idle.
//  5. reset asserted mid-GATE -> next cycle all outputs 0, range=0; start pulse afterwards behaves as scenario 1.
//  6. start re-pulsed at cycles 10 and 1003 (busy) -> ignored; single latch at 1006.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// Shared constants for the frequency-meter measurement controller: FSM state
// encoding, gate range codes and the elaboration-time gate-length function.
package freq_meas_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_GATE   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_LATCH  = 3'd4;

  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;

  // Gate length in sys_clk cycles for range r: gate_cycles / 10^r (integer divide).
  function automatic int gate_len(input int gate_cycles, input int r);
    int div;
    div = 1;
    for (int i = 0; i < r; i++) div = div * 10;
    return gate_cycles / div;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down counter with zero flag; times both the gate window and the
// settle interval of a measurement.
module gate_timer #(
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  // Load has priority; the counter holds at zero rather than wrapping.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/freq_meas_ctrl.sv
// Measurement sequencer: clear counter, open an exact gate, settle, latch.
// Optional auto-ranging on overflow is enabled by defining AUTO_RANGE_EN.
module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int GATE_CYCLES   = 50_000_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int TW            = 26
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cont,
  input  logic       ovf,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       latch,
  output logic       done,
  output logic       busy,
  output logic [1:0] range,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam logic [TW-1:0] LOAD_R0     = TW'(gate_len(GATE_CYCLES, 0) - 1);
  localparam logic [TW-1:0] LOAD_R1     = TW'(gate_len(GATE_CYCLES, 1) - 1);
  localparam logic [TW-1:0] LOAD_R2     = TW'(gate_len(GATE_CYCLES, 2) - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [1:0]    range_q, range_d;
  logic          err_q, err_d;
  logic          ovf_seen_q, ovf_seen_d;
  logic          cnt_clr_q, cnt_en_q, latch_q, done_q, busy_q;
  logic          pulse_d;
  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val, gate_load;

  always_comb begin
    case (range_q)
      RANGE_100MS: gate_load = LOAD_R1;
      RANGE_10MS:  gate_load = LOAD_R2;
      default:     gate_load = LOAD_R0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    range_d    = range_q;
    err_d      = err_q;
    ovf_seen_d = ovf_seen_q;
    pulse_d    = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          range_d = RANGE_1S;
          err_d   = 1'b0;
        end else if (cont) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        tmr_load   = 1'b1;
        tmr_val    = gate_load;
        ovf_seen_d = 1'b0;
        state_d    = ST_GATE;
      end
      ST_GATE: begin
        ovf_seen_d = ovf_seen_q | ovf;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LOAD;
          state_d  = ST_SETTLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        ovf_seen_d = ovf_seen_q | ovf;
        if (tmr_zero) begin
          state_d = ST_LATCH;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_LATCH: begin
`ifdef AUTO_RANGE_EN
        if (ovf_seen_q && (range_q < RANGE_10MS)) begin
          // Overflowed with a shorter gate still available: retry without latching.
          range_d = range_q + 2'd1;
          state_d = ST_CLEAR;
        end else begin
          pulse_d = 1'b1;
          if (ovf_seen_q) err_d = 1'b1;
          state_d = ST_IDLE;
        end
`else
        pulse_d = 1'b1;
        err_d   = ovf_seen_q;
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  gate_timer #(.TW(TW)) u_gate_timer (
    .clk      (sys_clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      range_q    <= RANGE_1S;
      err_q      <= 1'b0;
      ovf_seen_q <= 1'b0;
      cnt_clr_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      range_q    <= range_d;
      err_q      <= err_d;
      ovf_seen_q <= ovf_seen_d;
      cnt_clr_q  <= (state_q == ST_CLEAR);
      cnt_en_q   <= (state_q == ST_GATE);
      latch_q    <= pulse_d;
      done_q     <= pulse_d;
      busy_q     <= (state_q != ST_IDLE);
    end
  end

  assign cnt_clr   = cnt_clr_q;
  assign cnt_en    = cnt_en_q;
  assign latch     = latch_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign range     = range_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Bench for freq_meas_ctrl at GATE_CYCLES=1000, SETTLE_CYCLES=4; expected latch
// events and gate lengths are queued at stimulus time and consumed by a monitor.
module tb_freq_meas_ctrl;

  localparam int GC = 1000;
  localparam int SC = 4;
  localparam int TW = 26;

  logic       sys_clk = 1'b0;
  logic       reset, start, cont, ovf;
  logic       cnt_clr, cnt_en, latch, done, busy, err;
  logic [1:0] rng;
  logic [2:0] dbg_state;

  freq_meas_ctrl #(.GATE_CYCLES(GC), .SETTLE_CYCLES(SC), .TW(TW)) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .start     (start),
    .cont      (cont),
    .ovf       (ovf),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .latch     (latch),
    .done      (done),
    .busy      (busy),
    .range     (rng),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock / edge index: after posedge number j (0-based), pe == j+1.
  always #5 sys_clk = ~sys_clk;
  int pe = 0;
  always @(posedge sys_clk) pe <= pe + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, pe - 1);
    end
  endtask

  // Scoreboard: {err, range, latch edge}
  logic [34:0] exp_q[$];
  int          gate_q[$];

  function automatic int mlen(input int g);
    return g + SC + 2;
  endfunction

  task automatic push_latch(input int cyc, input logic [1:0] r, input logic e);
    exp_q.push_back({e, r, 32'(cyc)});
  endtask

  // Monitor
  int   last_clr  = -10;
  int   en_rise   = 0;
  logic prev_en   = 1'b0;
  bit   abort_run = 1'b0;

  always @(negedge sys_clk) begin
    logic [34:0] e;
    int g;
    if (cnt_clr === 1'b1) last_clr = pe - 1;
    if (cnt_en === 1'b1 && prev_en === 1'b0) begin
      en_rise = pe - 1;
      check("clr_to_en", 64'(en_rise), 64'(last_clr + 1));
    end
    if (cnt_en === 1'b0 && prev_en === 1'b1) begin
      if (abort_run) begin
        abort_run = 1'b0;
      end else if (gate_q.size() == 0) begin
        check("gate_unexp", 64'(pe - 1 - en_rise), 64'(0));
      end else begin
        g = gate_q.pop_front();
        check("gate_len", 64'(pe - 1 - en_rise), 64'(g));
      end
    end
    prev_en = cnt_en;
    if (latch === 1'b1 || done === 1'b1) begin
      check("done_eq_latch", 64'(done), 64'(latch));
      if (latch === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("latch_unexp", 64'(pe - 1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("latch_cycle", 64'(pe - 1), 64'(e[31:0]));
          check("latch_range", 64'(rng), 64'(e[33:32]));
          check("latch_err", 64'(err), 64'(e[34]));
        end
      end
    end
  end

  // Driver tasks
  task automatic start_meas(output int k);
    @(negedge sys_clk);
    start = 1'b1;
    k = pe;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_edge(input int target);
    while (pe - 1 < target) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (busy !== 1'b0 && n < limit);
    if (busy !== 1'b0) check("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clr"}, 64'(cnt_clr), 64'(0));
    check({tag, "_en"}, 64'(cnt_en), 64'(0));
    check({tag, "_latch"}, 64'(latch), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_range"}, 64'(rng), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    cont  = 1'b0;
    ovf   = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_all_zero("rst");
    reset = 1'b0;

    // 1: basic measurement and latency
    start_meas(k);
    gate_q.push_back(GC);
    push_latch(k + mlen(GC), 2'd0, 1'b0);
    wait_edge(k + 1);
    check("s1_clr", 64'(cnt_clr), 64'(1));
    check("s1_busy", 64'(busy), 64'(1));
    wait_edge(k + 2);
    check("s1_en", 64'(cnt_en), 64'(1));
    wait_edge(k + 1006);
    check("s1_busy_latch", 64'(busy), 64'(1));
    wait_edge(k + 1007);
    check("s1_busy_end", 64'(busy), 64'(0));

    // 2: single overflow pulse in the gate
    start_meas(k);
    gate_q.push_back(GC);
`ifdef AUTO_RANGE_EN
    gate_q.push_back(GC / 10);
    push_latch(k + mlen(GC) + mlen(GC / 10), 2'd1, 1'b0);
`else
    push_latch(k + mlen(GC), 2'd0, 1'b1);
`endif
    wait_edge(k + 499);
    ovf = 1'b1;
    @(negedge sys_clk);
    ovf = 1'b0;
    wait_idle(3000);

    // 3: overflow held through every range
    ovf = 1'b1;
    start_meas(k);
    gate_q.push_back(GC);
`ifdef AUTO_RANGE_EN
    gate_q.push_back(GC / 10);
    gate_q.push_back(GC / 100);
    push_latch(k + mlen(GC) + mlen(GC / 10) + mlen(GC / 100), 2'd2, 1'b1);
`else
    push_latch(k + mlen(GC), 2'd0, 1'b1);
`endif
    wait_idle(3000);
    ovf = 1'b0;
    check("s3_err_sticky", 64'(err), 64'(1));
    start_meas(k);
    gate_q.push_back(GC);
    push_latch(k + mlen(GC), 2'd0, 1'b0);
    check("s3_err_cleared", 64'(err), 64'(0));
    check("s3_range_reset", 64'(rng), 64'(0));
    wait_idle(3000);

    // 4: continuous mode, dropped mid-gate of the 4th measurement
    @(negedge sys_clk);
    cont = 1'b1;
    k = pe;
    for (int i = 0; i < 4; i++) begin
      gate_q.push_back(GC);
      push_latch(k + mlen(GC) + i * (mlen(GC) + 1), 2'd0, 1'b0);
    end
    wait_edge(k + 3 * 1007 + 500);
    check("s4_busy_mid", 64'(cnt_en), 64'(1));
    cont = 1'b0;
    wait_edge(k + 4 * 1007 + 200);
    check("s4_idle", 64'(busy), 64'(0));
    check("s4_drained", 64'(exp_q.size()), 64'(0));

    // 5: reset mid-gate, then a clean measurement
    start_meas(k);
    wait_edge(k + 299);
    abort_run = 1'b1;
    reset = 1'b1;
    @(negedge sys_clk);
    check_all_zero("s5_rst");
    reset = 1'b0;
    start_meas(k);
    gate_q.push_back(GC);
    push_latch(k + mlen(GC), 2'd0, 1'b0);
    wait_edge(k + 1);
    check("s5_clr", 64'(cnt_clr), 64'(1));
    wait_idle(3000);

    // 6: start re-pulsed while busy is ignored
    start_meas(k);
    gate_q.push_back(GC);
    push_latch(k + mlen(GC), 2'd0, 1'b0);
    wait_edge(k + 9);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_edge(k + 1002);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_edge(k + 1008);
    check("s6_idle", 64'(busy), 64'(0));
    repeat (20) @(negedge sys_clk);
    check("s6_no_restart", 64'(busy), 64'(0));

    repeat (5) @(negedge sys_clk);
    check("final_exp_q", 64'(exp_q.size()), 64'(0));
    check("final_gate_q", 64'(gate_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
